car_update_sched: RTL and testbench

Time-multiplexed movement scheduler for the road cars. It generates the slowdown tick and walks a single shared update engine across all cars, one car per clock. It holds per-car X/Y/speed state, loaded by a config port, and exports flattened positions to the renderer and collision logic. It also reports frame completion and tick overrun.

---
 rtl/car_update_sched.sv | 177 +++++++++++++++++
 tb/tb_car_update_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_update_sched.sv
// car_update_sched: time-multiplexed movement scheduler for the road cars.
// A slowdown counter produces ticks. Each accepted tick walks one shared
// update engine across every car, one car per clock.
// Optional feature macro: CAR_SCHED_DIR_EN adds a per-car direction (i_Cfg_Dir).
// Ports:
//   i_Clk, i_Rst         clock, synchronous active-high reset
//   i_Enable, i_Level    counter run/pause, difficulty (threshold shift)
//   i_Cfg_*              config write port (accepted only while o_Cfg_Ready)
//   o_Car_X, o_Car_Y     flattened per-car positions, car k at [k*6 +: 6]
//   o_Busy               frame in progress (UPDATE or DONE)
//   o_Frame_Done         one-cycle pulse after the last car updates
//   o_Overrun            sticky, set when a tick is lost
module car_update_sched #(
  parameter int unsigned NUM_CARS      = 10,
  parameter int unsigned c_MAX_X       = 40,
  parameter int unsigned c_SLOW_COUNT  = 2000000,
  parameter int unsigned COUNTER_WIDTH = 26
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Enable,
  input  logic [2:0]            i_Level,
  input  logic                  i_Cfg_We,
  input  logic [5:0]            i_Cfg_Idx,
  input  logic [5:0]            i_Cfg_X,
  input  logic [5:0]            i_Cfg_Y,
  input  logic [2:0]            i_Cfg_Speed,
`ifdef CAR_SCHED_DIR_EN
  input  logic                  i_Cfg_Dir,
`endif
  output logic                  o_Cfg_Ready,
  output logic [NUM_CARS*6-1:0] o_Car_X,
  output logic [NUM_CARS*6-1:0] o_Car_Y,
  output logic                  o_Busy,
  output logic                  o_Frame_Done,
  output logic                  o_Overrun
);

  localparam int unsigned POS_W    = 6;
  localparam logic [31:0] MIN_THR  = 32'(NUM_CARS + 2);
  localparam logic [6:0]  MAX_X7   = 7'(c_MAX_X);
  localparam logic [5:0]  X_RIGHT  = 6'(c_MAX_X - 1);
  localparam logic [5:0]  LAST_IDX = 6'(NUM_CARS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_DONE} state_t;

  state_t                   state, state_next;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [5:0]               index;
  logic                     pending;
  logic                     consume;
  logic                     tick;
  logic                     cfg_hit;
  logic [5:0]               cfg_x_clamped;
  logic [31:0]              shifted_thr;
  logic [31:0]              thr;

  logic [POS_W-1:0] car_x     [NUM_CARS];
  logic [POS_W-1:0] car_y     [NUM_CARS];
  logic [2:0]       car_speed [NUM_CARS];
`ifdef CAR_SCHED_DIR_EN
  logic             car_dir   [NUM_CARS];
`endif

  // Rightward move: wrap to the left edge when the sum leaves the grid.
  function automatic logic [5:0] move_right(input logic [5:0] x, input logic [2:0] sp);
    logic [6:0] sum;
    sum = 7'(x) + 7'(sp);
    return (sum < MAX_X7) ? sum[5:0] : 6'd0;
  endfunction

`ifdef CAR_SCHED_DIR_EN
  // Leftward move: wrap to the right edge on underflow.
  function automatic logic [5:0] move_left(input logic [5:0] x, input logic [2:0] sp);
    return (x >= 6'(sp)) ? (x - 6'(sp)) : X_RIGHT;
  endfunction
`endif

  // Tick threshold, clamped so a whole frame always fits between ticks.
  always_comb begin
    shifted_thr = 32'(c_SLOW_COUNT) >> i_Level;
    thr         = (shifted_thr < MIN_THR) ? MIN_THR : shifted_thr;
  end

  assign tick          = i_Enable && (32'(counter) >= thr);
  assign cfg_hit       = (state == ST_IDLE) && i_Cfg_We && (32'(i_Cfg_Idx) < 32'(NUM_CARS));
  assign cfg_x_clamped = (7'(i_Cfg_X) >= MAX_X7) ? 6'd0 : i_Cfg_X;

  // FSM state register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next state; a config write in IDLE defers the frame
  always_comb begin
    state_next = state;
    consume    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending && !i_Cfg_We) begin
          state_next = ST_UPDATE;
          consume    = 1'b1;
        end
      end
      ST_UPDATE: if (index == LAST_IDX) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Slowdown counter, pending tick, car index and status outputs
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      counter      <= '0;
      pending      <= 1'b0;
      index        <= 6'd0;
      o_Busy       <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Overrun    <= 1'b0;
      o_Cfg_Ready  <= 1'b1;
    end else begin
      if (i_Enable) counter <= tick ? '0 : counter + COUNTER_WIDTH'(1);
      if (consume) begin
        // a tick landing on the consuming cycle re-arms pending
        pending <= tick;
      end else if (tick) begin
        if (pending) o_Overrun <= 1'b1;
        pending <= 1'b1;
      end
      if (consume) index <= 6'd0;
      else if (state == ST_UPDATE && index != LAST_IDX) index <= index + 6'd1;
      o_Busy       <= (state_next != ST_IDLE);
      o_Frame_Done <= (state_next == ST_DONE);
      o_Cfg_Ready  <= (state_next == ST_IDLE);
    end
  end

  // Per-car state: config writes in IDLE, engine updates in UPDATE
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
        car_x[k]     <= 6'(k % c_MAX_X);
        car_y[k]     <= 6'(k + 1);
        car_speed[k] <= 3'd1;
`ifdef CAR_SCHED_DIR_EN
        car_dir[k]   <= 1'b0;
`endif
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
        if (cfg_hit && i_Cfg_Idx == 6'(k)) begin
          car_x[k]     <= cfg_x_clamped;
          car_y[k]     <= i_Cfg_Y;
          car_speed[k] <= i_Cfg_Speed;
`ifdef CAR_SCHED_DIR_EN
          car_dir[k]   <= i_Cfg_Dir;
`endif
        end else if (state == ST_UPDATE && index == 6'(k)) begin
`ifdef CAR_SCHED_DIR_EN
          car_x[k] <= car_dir[k] ? move_left(car_x[k], car_speed[k])
                                 : move_right(car_x[k], car_speed[k]);
`else
          car_x[k] <= move_right(car_x[k], car_speed[k]);
`endif
        end
      end
    end
  end

  // Flatten registered positions onto the output buses
  for (genvar g = 0; g < NUM_CARS; g++) begin : g_flat
    assign o_Car_X[g*POS_W +: POS_W] = car_x[g];
    assign o_Car_Y[g*POS_W +: POS_W] = car_y[g];
  end

endmodule

// File: tb/tb_car_update_sched.sv
// Randomized + directed bench for car_update_sched against a cycle-level
// behavioural model built from integer frame phase and per-car arrays.
module tb_car_update_sched;

  localparam int N    = 4;
  localparam int MAXX = 10;
  localparam int SLOW = 20;
  localparam int CW   = 8;

  logic           clk = 1'b0;
  logic           rst, en, we;
  logic [2:0]     lvl, csp;
  logic [5:0]     idx, cx, cy;
`ifdef CAR_SCHED_DIR_EN
  logic           cdir;
`endif
  logic           o_Cfg_Ready, o_Busy, o_Frame_Done, o_Overrun;
  logic [N*6-1:0] o_Car_X, o_Car_Y;

  always #5 clk = ~clk;

  car_update_sched #(
    .NUM_CARS(N), .c_MAX_X(MAXX), .c_SLOW_COUNT(SLOW), .COUNTER_WIDTH(CW)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Level(lvl),
    .i_Cfg_We(we), .i_Cfg_Idx(idx), .i_Cfg_X(cx), .i_Cfg_Y(cy), .i_Cfg_Speed(csp),
`ifdef CAR_SCHED_DIR_EN
    .i_Cfg_Dir(cdir),
`endif
    .o_Cfg_Ready(o_Cfg_Ready), .o_Car_X(o_Car_X), .o_Car_Y(o_Car_Y),
    .o_Busy(o_Busy), .o_Frame_Done(o_Frame_Done), .o_Overrun(o_Overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: mphase -1 = idle, 0..N-1 = updating that car, N = done cycle
  int mx [N];
  int my [N];
  int ms [N];
  int md [N];
  int mcnt, mpend, movr, mphase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int dut_x(input int k);
    return 32'(o_Car_X[k*6 +: 6]);
  endfunction

  function automatic int dut_y(input int k);
    return 32'(o_Car_Y[k*6 +: 6]);
  endfunction

  function automatic int moved(input int x, input int sp, input int dir);
    if (dir != 0) return (x >= sp) ? x - sp : MAXX - 1;
    return (x + sp < MAXX) ? x + sp : 0;
  endfunction

  task automatic model_step();
    int  thr;
    int  ci;
    bit  tick;
    bit  consume;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        mx[k] = k % MAXX; my[k] = k + 1; ms[k] = 1; md[k] = 0;
      end
      mcnt = 0; mpend = 0; movr = 0; mphase = -1;
    end else begin
      thr = SLOW >> lvl;
      if (thr < N + 2) thr = N + 2;
      tick = en && (mcnt >= thr);
      if (en) mcnt = tick ? 0 : mcnt + 1;
      consume = (mphase < 0) && (mpend != 0) && !we;
      ci = int'(idx);
      if (mphase < 0 && we && ci < N) begin
        mx[ci] = (int'(cx) >= MAXX) ? 0 : int'(cx);
        my[ci] = int'(cy);
        ms[ci] = int'(csp);
`ifdef CAR_SCHED_DIR_EN
        md[ci] = int'(cdir);
`endif
      end
      if (mphase >= 0 && mphase < N) mx[mphase] = moved(mx[mphase], ms[mphase], md[mphase]);
      if (consume)                         mphase = 0;
      else if (mphase >= 0 && mphase < N)  mphase = mphase + 1;
      else if (mphase == N)                mphase = -1;
      if (consume) mpend = int'(tick);
      else if (tick) begin
        if (mpend != 0) movr = 1;
        mpend = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      check($sformatf("car%0d_x", k), 32'(dut_x(k)), 32'(mx[k]));
      check($sformatf("car%0d_y", k), 32'(dut_y(k)), 32'(my[k]));
    end
    check("busy",    32'(o_Busy),       32'(mphase >= 0));
    check("done",    32'(o_Frame_Done), 32'(mphase == N));
    check("ready",   32'(o_Cfg_Ready),  32'(mphase < 0));
    check("overrun", 32'(o_Overrun),    32'(movr));
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_cycle();
    run_cycle();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int i, input int x, input int y, input int sp, input int dir);
    we = 1'b1; idx = 6'(i); cx = 6'(x); cy = 6'(y); csp = 3'(sp);
`ifdef CAR_SCHED_DIR_EN
    cdir = (dir != 0);
`else
    if (dir != 0) $display("note: direction ignored in this build");
`endif
    run_cycle();
    we = 1'b0;
  endtask

  task automatic wait_frame(input int budget, output int cyc);
    cyc = 0;
    do begin
      run_cycle();
      cyc++;
    end while (o_Frame_Done !== 1'b1 && cyc < budget);
    check("wait_frame", 32'(o_Frame_Done), 32'd1);
  endtask

  int cyc, pulses;

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; lvl = 3'd0;
    idx = '0; cx = '0; cy = '0; csp = '0;
`ifdef CAR_SCHED_DIR_EN
    cdir = 1'b0;
`endif
    mcnt = 0; mpend = 0; movr = 0; mphase = -1;

    // 1: reset state, first frame latency and result
    do_reset();
    for (int k = 0; k < N; k++) begin
      check("rst_x", 32'(dut_x(k)), 32'(k));
      check("rst_y", 32'(dut_y(k)), 32'(k + 1));
    end
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_ready", 32'(o_Cfg_Ready), 32'd1);
    en = 1'b1;
    wait_frame(60, cyc);
    check("s1_latency", 32'(cyc), 32'd26);
    for (int k = 0; k < N; k++) check("s1_x", 32'(dut_x(k)), 32'(k + 1));
    run_cycle();
    check("s1_done_pulse", 32'(o_Frame_Done), 32'd0);

    // 2: wrap on the right edge
    cfg_write(2, 8, 3, 3, 0);
    check("s2_wr_x", 32'(dut_x(2)), 32'd8);
    wait_frame(60, cyc);
    check("s2_wrap_x", 32'(dut_x(2)), 32'd0);
    check("s2_y1", 32'(dut_y(1)), 32'd2);

    // 3: writes outside IDLE, bad index, X clamp
    cyc = 0;
    do begin run_cycle(); cyc++; end while (o_Busy !== 1'b1 && cyc < 60);
    check("s3_busy_seen", 32'(o_Busy), 32'd1);
    we = 1'b1; idx = 6'd1; cx = 6'd7; cy = 6'd9; csp = 3'd5;
    run_cycle();
    run_cycle();
    we = 1'b0;
    wait_frame(20, cyc);
    check("s3_busy_write_y", 32'(dut_y(1)), 32'd2);
    run_cycle();
    cfg_write(5, 3, 3, 2, 0);
    cfg_write(3, 12, 4, 0, 0);
    check("s3_x_clamp", 32'(dut_x(3)), 32'd0);

    // 4: clamped threshold, then forced overrun
    lvl = 3'd7;
    pulses = 0;
    for (int i = 0; i < 42; i++) begin
      run_cycle();
      if (o_Frame_Done === 1'b1) pulses++;
    end
    check("s4_frames", 32'(pulses >= 5 && pulses <= 7), 32'd1);
    check("s4_no_ovr", 32'(o_Overrun), 32'd0);
    we = 1'b1; idx = 6'd63;
    for (int i = 0; i < 20; i++) run_cycle();
    we = 1'b0;
    check("s4_ovr_set", 32'(o_Overrun), 32'd1);
    for (int i = 0; i < 30; i++) run_cycle();
    check("s4_ovr_sticky", 32'(o_Overrun), 32'd1);

    // 5: pause holds the counter; reset mid-frame aborts it
    lvl = 3'd0;
    do_reset();
    for (int i = 0; i < 5; i++) run_cycle();
    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      run_cycle();
      if (o_Frame_Done === 1'b1) pulses++;
    end
    check("s5_pause_no_done", 32'(pulses), 32'd0);
    en = 1'b1;
    cyc = 0;
    do begin run_cycle(); cyc++; end while (o_Busy !== 1'b1 && cyc < 60);
    check("s5_resume_latency", 32'(cyc), 32'd17);
    run_cycle();
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    for (int k = 0; k < N; k++) check("s5_rst_x", 32'(dut_x(k)), 32'(k));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      if (o_Frame_Done === 1'b1) pulses++;
    end
    check("s5_abort_no_done", 32'(pulses), 32'd0);

`ifdef CAR_SCHED_DIR_EN
    // 6: leftward wrap
    do_reset();
    cfg_write(0, 1, 1, 2, 1);
    wait_frame(60, cyc);
    check("s6_left_wrap", 32'(dut_x(0)), 32'd9);
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) lvl = 3'($urandom_range(0, 7));
      we  = ($urandom_range(0, 7) == 0);
      idx = 6'($urandom_range(0, 5));
      cx  = 6'($urandom_range(0, 15));
      cy  = 6'($urandom_range(0, 63));
      csp = 3'($urandom_range(0, 7));
`ifdef CAR_SCHED_DIR_EN
      cdir = 1'($urandom_range(0, 1));
`endif
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
